// File: rtl/sram_like_resp_pkg.sv
// sram_like_resp_pkg: shared definitions for the SRAM-like responder.
//   size_e    : access-size encodings carried on the req channel (informational)
//   q_entry_t : one outstanding-request slot (valid, wait counter, captured data)
package sram_like_resp_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned CNT_W   = 4;   // holds LATENCY up to 15
    localparam int unsigned VALID_W = 1;

    typedef struct packed {
        logic [VALID_W-1:0] valid;
        logic [CNT_W-1:0]   cnt;
        logic [DATA_W-1:0]  data;
    } q_entry_t;

endpackage

// File: rtl/sram_like_resp_queue.sv
// resp_queue: circular FIFO of outstanding requests. Each valid entry carries
// a wait counter that counts up once per cycle and saturates at LATENCY; the
// head is ready to be answered once its counter has reached LATENCY.
//   clk, resetn : clock, synchronous active-low reset (entries discarded)
//   push        : enqueue push_data with wait counter 1 (caller ensures !full)
//   pop         : dequeue the head (caller only pops when head_ready)
//   head_ready  : head valid and its wait has elapsed
//   head_data   : data captured for the head entry
//   full        : QDEPTH entries outstanding
module resp_queue
    import sram_like_resp_pkg::*;
#(
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              head_ready,
    output logic [DATA_W-1:0] head_data,
    output logic              full
);

    localparam int unsigned PW = $clog2(QDEPTH);
    localparam int unsigned CW = PW + 1;

    q_entry_t        ents [QDEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;

    assign head_ready = ents[head].valid[0] && (ents[head].cnt == CNT_W'(LATENCY));
    assign head_data  = ents[head].data;
    assign full       = (count == CW'(QDEPTH));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                ents[PW'(i)].valid <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                if (ents[PW'(i)].valid[0] && ents[PW'(i)].cnt != CNT_W'(LATENCY)) begin
                    ents[PW'(i)].cnt <= ents[PW'(i)].cnt + 1'b1;
                end
            end
            if (pop) begin
                ents[head].valid <= '0;
                head             <= head + 1'b1;
            end
            // Push never targets the head slot while it is valid (not full),
            // so this write cannot collide with the pop above.
            if (push) begin
                ents[tail] <= '{valid: 1'b1, cnt: CNT_W'(1), data: push_data};
                tail       <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_resp.sv
// sram_like_resp: responder end of the SRAM-like req/addr_ok/data_ok bus.
// Requests are performed on a local word-addressed memory in the accept
// cycle and answered in order after LATENCY cycles.
//   clk, resetn : clock, synchronous active-low reset (memory not cleared)
//   req, wr     : request valid, 1 = write
//   size        : access size (informational only)
//   wstrb       : byte enables for writes
//   addr, wdata : byte address (word index addr[ADDR_W+1:2]), write data
//   stall       : external backpressure, forces addr_ok low
//   addr_ok     : request accepted when req & addr_ok
//   data_ok     : one-cycle response pulse for the oldest request
//   rdata       : read data, valid while data_ok
module sram_like_resp
    import sram_like_resp_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned QDEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    logic [31:0]       mem [0:(1 << ADDR_W) - 1];
    logic [ADDR_W-1:0] widx;
    logic              accept;
    logic [31:0]       rword;
    logic              full;
    logic              head_ready;
    logic [31:0]       head_data;
    logic              unused_bits;

    // Size and the bits outside the word index do not affect behaviour.
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    assign addr_ok = ~full & ~stall;
    assign accept  = req & addr_ok;
    assign widx    = addr[ADDR_W+1:2];
    assign rword   = wr ? '0 : mem[widx];

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_ok <= 1'b0;
            rdata   <= '0;
        end else begin
            data_ok <= head_ready;
            if (head_ready) begin
                rdata <= head_data;
            end
        end
    end

    resp_queue #(
        .QDEPTH  (QDEPTH),
        .LATENCY (LATENCY)
    ) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_data  (rword),
        .pop        (head_ready),
        .head_ready (head_ready),
        .head_data  (head_data),
        .full       (full)
    );

endmodule
